// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel-stream blocks (frame reader now, frame
// writer later): default widths and the per-pixel FSM state encoding.
//
// Contents:
//   PS_INT_WIDTH   bits per colour sample / memory word
//   PS_DIM_WIDTH   bits of the width/height inputs
//   PS_ADDR_WIDTH  memory word-address width
//   px_state_t     IDLE, RD_R, RD_G, RD_B, CAP, SEND (IDLE encodes as 0)
//   is_read_state  true for the states that issue a memory read
package pixel_stream_pkg;

    localparam int PS_INT_WIDTH  = 8;
    localparam int PS_DIM_WIDTH  = 13;
    localparam int PS_ADDR_WIDTH = 20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_R = 3'd1,
        ST_RD_G = 3'd2,
        ST_RD_B = 3'd3,
        ST_CAP  = 3'd4,
        ST_SEND = 3'd5
    } px_state_t;

    function automatic logic is_read_state(input px_state_t s);
        return (s == ST_RD_R) || (s == ST_RD_G) || (s == ST_RD_B);
    endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Raster position counters for one frame.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      restart at pixel 0 (frame start)
//   advance    step to the next pixel in raster order
//   width      pixels per line of the current frame (non-zero while used)
//   npix       pixels in the current frame (non-zero while used)
//   idx        raster index of the current pixel
//   sof        current pixel is the first of the frame
//   eol        current pixel is the last of its line
//   eof        current pixel is the last of the frame
module frame_pixel_counter
    import pixel_stream_pkg::*;
#(
    parameter int DIM_WIDTH = PS_DIM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [DIM_WIDTH-1:0]   width,
    input  logic [2*DIM_WIDTH-1:0] npix,
    output logic [2*DIM_WIDTH-1:0] idx,
    output logic                   sof,
    output logic                   eol,
    output logic                   eof
);

    logic [DIM_WIDTH-1:0] col;
    logic [DIM_WIDTH-1:0] row;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx <= '0;
            col <= '0;
            row <= '0;
        end else if (advance) begin
            idx <= idx + 1'b1;
            if (eol) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // With width==1 col is always 0 == width-1, so every pixel ends a line.
    assign sof = (idx == '0);
    assign eol = (col == width - 1'b1);
    assign eof = (idx == npix - 1'b1);

endmodule

// File: rtl/rgb_frame_reader.sv
// Reads a planar RGB frame (R plane, G plane, B plane; each width*height
// bytes in raster order) from a 1-cycle-latency synchronous memory and emits
// one RGB pixel per handshake, with sof/eol/eof markers.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse starting a frame (ignored while busy)
//   width, height   frame geometry, sampled on an accepted start
//   mem_addr        read address (holds its last value when mem_rd=0)
//   mem_rd          read strobe; mem_rdata is valid the following cycle
//   mem_rdata       read data
//   R, G, B         pixel samples
//   dout_valid      pixel valid
//   dout_ready      sink ready
//   sof, eol, eof   first pixel / last of line / last of frame
//   busy            frame in progress
//   done            one-cycle pulse when a frame ends (normal or error)
//   err             frame did not fit the address space; sticky to next start
//   fsm_state       current FSM state, for observation
//
// Handshake: a pixel transfers on a rising edge where dout_valid and
// dout_ready are both 1; once dout_valid is raised, R/G/B and the flags stay
// constant and dout_valid stays high until that transfer happens.
module rgb_frame_reader
    import pixel_stream_pkg::*;
#(
    parameter int INT_WIDTH  = PS_INT_WIDTH,
    parameter int DIM_WIDTH  = PS_DIM_WIDTH,
    parameter int ADDR_WIDTH = PS_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [INT_WIDTH-1:0]  mem_rdata,
    output logic [INT_WIDTH-1:0]  R,
    output logic [INT_WIDTH-1:0]  G,
    output logic [INT_WIDTH-1:0]  B,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output px_state_t             fsm_state
);

    localparam int NPIX_W = 2 * DIM_WIDTH;
    // Wide enough for 3*npix and for 2**ADDR_WIDTH without wrap-around.
    localparam int CHK_W  = ((NPIX_W > ADDR_WIDTH) ? NPIX_W : ADDR_WIDTH) + 2;

    px_state_t state_q, state_d;

    logic [DIM_WIDTH-1:0]  width_q;
    logic [NPIX_W-1:0]     npix_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic [NPIX_W-1:0]     idx;
    logic                  cnt_sof, cnt_eol, cnt_eof;
    logic                  cnt_clear, cnt_adv;

    logic [NPIX_W-1:0]     start_npix;
    logic [CHK_W-1:0]      start_span;
    logic [CHK_W-1:0]      addr_limit;
    logic                  too_big;
    logic                  empty;
    logic                  accept;

    logic [CHK_W-1:0]      idx_w;
    logic [CHK_W-1:0]      addr_wide;
    logic                  rd_c;

    // Geometry of the requested frame, evaluated at the start pulse.
    assign start_npix = NPIX_W'(width) * NPIX_W'(height);
    assign start_span = CHK_W'(start_npix) + (CHK_W'(start_npix) << 1);
    assign addr_limit = CHK_W'(1) << ADDR_WIDTH;
    assign too_big    = (start_span > addr_limit);
    assign empty      = (start_npix == '0);

    assign idx_w = CHK_W'(idx);

    frame_pixel_counter #(
        .DIM_WIDTH (DIM_WIDTH)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .width   (width_q),
        .npix    (npix_q),
        .idx     (idx),
        .sof     (cnt_sof),
        .eol     (cnt_eol),
        .eof     (cnt_eof)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        addr_wide = idx_w;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    cnt_clear = 1'b1;
                    if (!empty && !too_big) begin
                        state_d = ST_RD_R;
                    end
                end
            end
            ST_RD_R: begin
                addr_wide = idx_w;
                state_d   = ST_RD_G;
            end
            ST_RD_G: begin
                addr_wide = CHK_W'(npix_q) + idx_w;
                state_d   = ST_RD_B;
            end
            ST_RD_B: begin
                addr_wide = (CHK_W'(npix_q) << 1) + idx_w;
                state_d   = ST_CAP;
            end
            ST_CAP: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dout_ready) begin
                    if (eof) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_adv = 1'b1;
                        state_d = ST_RD_R;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The frame was range-checked at start, so the truncation drops only
    // zero bits.
    assign rd_c     = is_read_state(state_q);
    assign mem_rd   = rd_c;
    assign mem_addr = rd_c ? ADDR_WIDTH'(addr_wide) : mem_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            width_q    <= '0;
            npix_q     <= '0;
            mem_addr_q <= '0;
            R          <= '0;
            G          <= '0;
            B          <= '0;
            dout_valid <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rd_c) begin
                mem_addr_q <= ADDR_WIDTH'(addr_wide);
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        width_q <= width;
                        npix_q  <= start_npix;
                        err     <= too_big;
                        // Degenerate or oversized frames end right away.
                        if (empty || too_big) begin
                            done <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                end
                // Each state captures the word requested by the previous one.
                ST_RD_G: R <= mem_rdata;
                ST_RD_B: G <= mem_rdata;
                ST_CAP: begin
                    B          <= mem_rdata;
                    dout_valid <= 1'b1;
                    sof        <= cnt_sof;
                    eol        <= cnt_eol;
                    eof        <= cnt_eof;
                end
                ST_SEND: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        if (eof) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_rgb_frame_reader.sv
module tb_rgb_frame_reader;
  import pixel_stream_pkg::*;

  localparam int IW = 8;
  localparam int DW = 13;
  localparam int AW = 6;
  localparam int MEM_WORDS = 1 << AW;
  localparam int PW = 3 * IW + 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [DW-1:0] width = '0;
  logic [DW-1:0] height = '0;
  logic [AW-1:0] mem_addr;
  logic mem_rd;
  logic [IW-1:0] mem_rdata;
  logic [IW-1:0] R, G, B;
  logic dout_valid;
  logic dout_ready = 1'b1;
  logic sof, eol, eof, busy, done, err;
  px_state_t fsm_state;

  always #5 clk = ~clk;

  rgb_frame_reader #(
    .INT_WIDTH (IW),
    .DIM_WIDTH (DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .width     (width),
    .height    (height),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .R         (R),
    .G         (G),
    .B         (B),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // 1-cycle-latency synchronous-read memory
  logic [IW-1:0] mem [MEM_WORDS];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails = 0;
  int rd_cnt = 0;
  int acc_cnt = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: pixel k of a w x h planar frame is (mem[k], mem[n+k], mem[2n+k]).
  task automatic push_frame(input int w, input int h);
    int n;
    logic [PW-1:0] e;
    n = w * h;
    for (int k = 0; k < n; k++) begin
      e = {mem[k], mem[n + k], mem[2 * n + k], (k == 0), ((k % w) == w - 1), (k == n - 1)};
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every cycle a pixel is presented it must equal the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) rd_cnt++;
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pixel: got %0h, expected no pixel", {R, G, B, sof, eol, eof});
        end else begin
          check("pixel", {R, G, B, sof, eol, eof}, exp_q[0]);
          if (dout_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end

  // Sink ready driver: 0 = always ready, 1 = random, 2 = 3-cycle stall on pixel 2
  int ready_mode = 0;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: dout_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (dout_valid && acc_cnt == 2 && stall_left > 0) begin
          dout_ready = 1'b0;
          stall_left--;
        end else begin
          dout_ready = 1'b1;
        end
      end
      default: dout_ready = 1'b1;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1;
    width = DW'(w);
    height = DW'(h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      if (done) return;
    end
    checks++;
    fails++;
    $display("FAIL done_timeout: got no done, expected done within 3000 cycles");
  endtask

  // extra_lat < 0 disables the latency check (random back-pressure)
  task automatic run_frame(input int w, input int h, input int extra_lat, input string tag);
    longint n;
    bit legal, big;
    int lat;
    n = longint'(w) * longint'(h);
    big = (3 * n > MEM_WORDS);
    legal = (n != 0) && !big;
    rd_cnt = 0;
    acc_cnt = 0;
    if (legal) push_frame(w, h);
    pulse_start(w, h);
    check({tag, "_busy"}, busy, legal);
    wait_done(lat);
    if (!legal) check({tag, "_done_lat"}, lat, 1);
    else if (extra_lat >= 0) check({tag, "_done_lat"}, lat, 5 * n + 1 + extra_lat);
    check({tag, "_reads"}, rd_cnt, legal ? 3 * n : 0);
    check({tag, "_accepted"}, acc_cnt, legal ? n : 0);
    check({tag, "_err"}, err, big);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic fill_identity();
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = IW'(a);
  endtask

  task automatic fill_random();
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = IW'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"}, {mem_addr, mem_rd, R, G, B, dout_valid, sof, eol, eof, busy, done, err}, '0);
    check({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w, h;
    fill_identity();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 4x2 identity frame: (0,8,16)..(7,15,23), full rate
    run_frame(4, 2, 0, "f4x2");

    // Same frame with a 3-cycle stall on pixel 2
    stall_left = 3;
    ready_mode = 2;
    run_frame(4, 2, 3, "f4x2_stall");
    ready_mode = 0;

    // Degenerate frames
    run_frame(0, 3, 0, "w0");
    run_frame(0, 5, 0, "h5w0");
    run_frame(4, 0, 0, "h0");

    // Address-space boundary: 3*21 = 63 fits, 3*22 = 66 and 3*24 = 72 do not
    fill_random();
    run_frame(3, 7, 0, "fit21");
    run_frame(2, 11, 0, "over22");
    run_frame(4, 6, 0, "over24");
    run_frame(8191, 8191, 0, "over_max");
    run_frame(1, 5, 0, "clear_err");

    // Start pulsed while busy must not disturb the frame in flight
    fill_random();
    fork
      run_frame(4, 2, 0, "busy_start");
      begin
        repeat (8) @(posedge clk);
        #1;
        start = 1'b1;
        width = DW'(2);
        height = DW'(1);
        @(posedge clk); #1;
        start = 1'b0;
      end
    join

    // Reset during RD_G of pixel 3 (cycle 17 after the start edge)
    fill_identity();
    push_frame(4, 2);
    acc_cnt = 0;
    pulse_start(4, 2);
    repeat (16) @(posedge clk);
    #1;
    check("pre_reset_accepted", acc_cnt, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    rst = 1'b0;
    run_frame(4, 2, 0, "after_reset");

    // Random geometry, random contents, random back-pressure
    ready_mode = 1;
    for (int t = 0; t < 12; t++) begin
      fill_random();
      w = $urandom_range(1, 7);
      h = $urandom_range(1, 21 / w);
      run_frame(w, h, -1, "rand");
    end
    ready_mode = 0;
    run_frame(1, 4, 0, "w1");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
